// File: rtl/vc_dest_arbiter.sv
// vc_dest_arbiter: pops at most one head word per cycle from the two class FIFOs
// (VC0/VC1) and forwards it as a registered beat to the 1:2 destination demux.
// Per-destination backpressure is applied per VC, so a blocked head on one VC never
// stalls the other.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration between the
// two VCs; without it, VC0 has strict priority.
module vc_dest_arbiter #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEST_BIT    = 4,
  parameter int unsigned INIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              vc0_empty,
  input  logic [DATA_W-1:0] vc0_data,
  input  logic              vc1_empty,
  input  logic [DATA_W-1:0] vc1_data,
  input  logic              d0_almost_full,
  input  logic              d1_almost_full,
  output logic              vc0_pop,
  output logic              vc1_pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              class_out,
  output logic              dest_out,
  output logic [1:0]        state,
  output logic [7:0]        cnt_dest0,
  output logic [7:0]        cnt_dest1
);

  typedef enum logic [1:0] {
    StReset  = 2'd0,
    StInit   = 2'd1,
    StIdle   = 2'd2,
    StActive = 2'd3
  } state_e;

  localparam int unsigned     InitW    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [InitW-1:0] InitLast = InitW'(INIT_CYCLES - 1);

  state_e             state_q;
  logic [InitW-1:0]   init_cnt_q;

  logic               vc0_blocked, vc1_blocked;
  logic               vc0_elig, vc1_elig, any_elig;
  logic               pick0, pick1;
  logic               run;
  logic               any_pop;
  logic [DATA_W-1:0]  fwd_data;
  logic               fwd_dest;

  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               class_q, class_d;
  logic               dest_q, dest_d;
  logic [7:0]         cnt0_q, cnt0_d;
  logic [7:0]         cnt1_q, cnt1_d;

  // Eligibility: head present and its own destination not almost full.
  always_comb begin
    vc0_blocked = vc0_data[DEST_BIT] ? d1_almost_full : d0_almost_full;
    vc1_blocked = vc1_data[DEST_BIT] ? d1_almost_full : d0_almost_full;
    vc0_elig    = !vc0_empty && !vc0_blocked;
    vc1_elig    = !vc1_empty && !vc1_blocked;
    any_elig    = vc0_elig || vc1_elig;
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers which VC was granted last; resets to VC1 so VC0 wins the first tie.
  logic last_grant_q;

  // Last-grant tracking, updated on every pop.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      last_grant_q <= 1'b1;
    end else if (any_pop) begin
      last_grant_q <= vc1_pop;
    end
  end

  // Round-robin pick: on a tie, the VC not granted last wins.
  always_comb begin
    pick1 = vc1_elig && (!vc0_elig || !last_grant_q);
    pick0 = vc0_elig && !pick1;
  end
`else
  // Strict priority pick: VC1 only when VC0 cannot go.
  always_comb begin
    pick0 = vc0_elig;
    pick1 = vc1_elig && !vc0_elig;
  end
`endif

  // Pops are combinational; reset_L gates them so they drop without waiting for a clock.
  always_comb begin
    run      = reset_L && ((state_q == StIdle) || (state_q == StActive));
    vc0_pop  = run && pick0;
    vc1_pop  = run && pick1;
    any_pop  = vc0_pop || vc1_pop;
    fwd_data = vc1_pop ? vc1_data : vc0_data;
    fwd_dest = fwd_data[DEST_BIT];
  end

  // Control FSM: RESET -> INIT (INIT_CYCLES clocks) -> IDLE <-> ACTIVE.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= StReset;
      init_cnt_q <= '0;
    end else begin
      case (state_q)
        StReset: begin
          state_q    <= StInit;
          init_cnt_q <= '0;
        end
        StInit: begin
          if (init_cnt_q == InitLast) begin
            state_q <= StIdle;
          end else begin
            init_cnt_q <= init_cnt_q + InitW'(1);
          end
        end
        StIdle, StActive: begin
          state_q <= any_elig ? StActive : StIdle;
        end
        default: state_q <= StReset;
      endcase
    end
  end

  // Output beat and per-destination counters; payload holds when nothing is popped.
  always_comb begin
    data_d  = data_q;
    class_d = class_q;
    dest_d  = dest_q;
    valid_d = 1'b0;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    if (any_pop) begin
      data_d  = fwd_data;
      class_d = vc1_pop;
      dest_d  = fwd_dest;
      valid_d = 1'b1;
      if (fwd_dest) begin
        cnt1_d = cnt1_q + 8'd1;
      end else begin
        cnt0_d = cnt0_q + 8'd1;
      end
    end
  end

  // Output registers, captured on the same edge as the pop.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      class_q <= 1'b0;
      dest_q  <= 1'b0;
      cnt0_q  <= 8'd0;
      cnt1_q  <= 8'd0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      class_q <= class_d;
      dest_q  <= dest_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign class_out = class_q;
  assign dest_out  = dest_q;
  assign state     = state_q;
  assign cnt_dest0 = cnt0_q;
  assign cnt_dest1 = cnt1_q;

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Bench for vc_dest_arbiter: a fixed vector table for reset/latency/backpressure,
// directed sequences (arbitration order, reset while active, counter wrap) and a
// randomized run against a cycle-level reference model.
module tb_vc_dest_arbiter;

  localparam int unsigned DW   = 8;
  localparam int unsigned DB   = 4;
  localparam int unsigned INIT = 2;

  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic          vc0_empty = 1'b1;
  logic [DW-1:0] vc0_data = '0;
  logic          vc1_empty = 1'b1;
  logic [DW-1:0] vc1_data = '0;
  logic          d0_almost_full = 1'b0;
  logic          d1_almost_full = 1'b0;
  logic          vc0_pop, vc1_pop;
  logic [DW-1:0] data_out;
  logic          valid_out, class_out, dest_out;
  logic [1:0]    state;
  logic [7:0]    cnt_dest0, cnt_dest1;

  vc_dest_arbiter #(
    .DATA_W     (DW),
    .DEST_BIT   (DB),
    .INIT_CYCLES(INIT)
  ) dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .vc0_empty     (vc0_empty),
    .vc0_data      (vc0_data),
    .vc1_empty     (vc1_empty),
    .vc1_data      (vc1_data),
    .d0_almost_full(d0_almost_full),
    .d1_almost_full(d1_almost_full),
    .vc0_pop       (vc0_pop),
    .vc1_pop       (vc1_pop),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .class_out     (class_out),
    .dest_out      (dest_out),
    .state         (state),
    .cnt_dest0     (cnt_dest0),
    .cnt_dest1     (cnt_dest1)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         cls_log[$];
  int         k;          // clock edges seen with reset released
  bit         m_last;
  logic [7:0] m_data, m_c0, m_c1;
  bit         m_valid, m_class, m_dest;
  logic [1:0] m_state;

  task automatic model_reset();
    k = 0; m_last = 1'b1; m_data = '0; m_valid = 0; m_class = 0; m_dest = 0;
    m_c0 = '0; m_c1 = '0; m_state = 2'd0;
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".state"}, 32'(state), 32'(m_state));
    check({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
    check({tag, ".data"},  32'(data_out), 32'(m_data));
    check({tag, ".class"}, 32'(class_out), 32'(m_class));
    check({tag, ".dest"},  32'(dest_out), 32'(m_dest));
    check({tag, ".cnt0"},  32'(cnt_dest0), 32'(m_c0));
    check({tag, ".cnt1"},  32'(cnt_dest1), 32'(m_c1));
  endtask

  // One clock: drive heads from the queues, check pops, then check the registered beat.
  task automatic cycle(input string tag);
    bit e0, e1, p0, p1, ok, a0, a1;
    logic [7:0] h0, h1, w;
    vc0_empty = (q0.size() == 0);
    vc1_empty = (q1.size() == 0);
    h0 = vc0_empty ? 8'($urandom) : q0[0];
    h1 = vc1_empty ? 8'($urandom) : q1[0];
    vc0_data = h0;
    vc1_data = h1;
    #1;
    if (!reset_L) begin
      model_reset();
      check_outs({tag, ".in_reset"});
    end
    a0 = h0[DB] ? d1_almost_full : d0_almost_full;
    a1 = h1[DB] ? d1_almost_full : d0_almost_full;
    e0 = !vc0_empty && !a0;
    e1 = !vc1_empty && !a1;
    ok = reset_L && (k > INIT);
    p0 = 0; p1 = 0;
    if (ok) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (e0 && e1) begin
        p0 = m_last; p1 = !m_last;
      end else begin
        p0 = e0; p1 = e1;
      end
`else
      p0 = e0; p1 = e1 && !e0;
`endif
    end
    check({tag, ".vc0_pop"}, 32'(vc0_pop), 32'(p0));
    check({tag, ".vc1_pop"}, 32'(vc1_pop), 32'(p1));
    @(posedge clk);
    #1;
    if (!reset_L) begin
      model_reset();
    end else begin
      if (k > INIT)       m_state = (e0 || e1) ? 2'd3 : 2'd2;
      else if (k == INIT) m_state = 2'd2;
      else                m_state = 2'd1;
      if (k < 1000) k++;
      if (p0 || p1) begin
        w = p0 ? h0 : h1;
        if (p0) void'(q0.pop_front()); else void'(q1.pop_front());
        m_data = w; m_class = p1; m_dest = w[DB]; m_valid = 1; m_last = p1;
        if (w[DB]) m_c1 = m_c1 + 8'd1; else m_c0 = m_c0 + 8'd1;
      end else begin
        m_valid = 0;
      end
    end
    check_outs(tag);
    if (valid_out) cls_log.push_back(class_out);
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit rl; bit e0; logic [7:0] d0; bit e1; logic [7:0] d1; bit a0; bit a1;
    bit p0; bit p1; bit valid; logic [7:0] data; bit cls; bit dst; logic [1:0] st;
    logic [7:0] c0; logic [7:0] c1;
  } vec_t;

  vec_t tbl[12];

  initial begin
    //          rl e0 d0     e1 d1     a0 a1  p0 p1 v  data   c  d  st     c0     c1
    tbl[0]  = '{1'b0, 1'b0, 8'h1F, 1'b1, 8'h00, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0};
    tbl[1]  = '{1'b0, 1'b0, 8'h1F, 1'b1, 8'h00, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0};
    tbl[2]  = '{1'b1, 1'b0, 8'h1F, 1'b1, 8'h00, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd1, 8'd0, 8'd0};
    tbl[3]  = '{1'b1, 1'b0, 8'h1F, 1'b1, 8'h00, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd1, 8'd0, 8'd0};
    tbl[4]  = '{1'b1, 1'b0, 8'h1F, 1'b1, 8'h00, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd2, 8'd0, 8'd0};
    tbl[5]  = '{1'b1, 1'b0, 8'h1F, 1'b1, 8'h00, 1'b0, 1'b0,
                1'b1, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b1, 2'd3, 8'd0, 8'd1};
    tbl[6]  = '{1'b1, 1'b0, 8'h1F, 1'b0, 8'h05, 1'b0, 1'b1,
                1'b0, 1'b1, 1'b1, 8'h05, 1'b1, 1'b0, 2'd3, 8'd1, 8'd1};
    tbl[7]  = '{1'b1, 1'b0, 8'h1F, 1'b1, 8'h00, 1'b0, 1'b1,
                1'b0, 1'b0, 1'b0, 8'h05, 1'b1, 1'b0, 2'd2, 8'd1, 8'd1};
    tbl[8]  = '{1'b1, 1'b0, 8'h1F, 1'b1, 8'h00, 1'b0, 1'b0,
                1'b1, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b1, 2'd3, 8'd1, 8'd2};
    tbl[9]  = '{1'b1, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0, 8'h1F, 1'b0, 1'b1, 2'd2, 8'd1, 8'd2};
    tbl[10] = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h10, 1'b0, 1'b1,
                1'b0, 1'b0, 1'b0, 8'h1F, 1'b0, 1'b1, 2'd2, 8'd1, 8'd2};
    tbl[11] = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h10, 1'b1, 1'b0,
                1'b0, 1'b1, 1'b1, 8'h10, 1'b1, 1'b1, 2'd3, 8'd1, 8'd3};

    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      reset_L = tbl[i].rl;
      vc0_empty = tbl[i].e0; vc0_data = tbl[i].d0;
      vc1_empty = tbl[i].e1; vc1_data = tbl[i].d1;
      d0_almost_full = tbl[i].a0; d1_almost_full = tbl[i].a1;
      #1;
      check($sformatf("tbl%0d.vc0_pop", i), 32'(vc0_pop), 32'(tbl[i].p0));
      check($sformatf("tbl%0d.vc1_pop", i), 32'(vc1_pop), 32'(tbl[i].p1));
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d.valid", i), 32'(valid_out), 32'(tbl[i].valid));
      check($sformatf("tbl%0d.data", i),  32'(data_out), 32'(tbl[i].data));
      check($sformatf("tbl%0d.class", i), 32'(class_out), 32'(tbl[i].cls));
      check($sformatf("tbl%0d.dest", i),  32'(dest_out), 32'(tbl[i].dst));
      check($sformatf("tbl%0d.state", i), 32'(state), 32'(tbl[i].st));
      check($sformatf("tbl%0d.cnt0", i),  32'(cnt_dest0), 32'(tbl[i].c0));
      check($sformatf("tbl%0d.cnt1", i),  32'(cnt_dest1), 32'(tbl[i].c1));
      @(negedge clk);
    end

    // Arbitration order with both VCs backlogged toward dest0.
    d0_almost_full = 0; d1_almost_full = 0;
    reset_L = 0;
    cycle("arb_rst"); cycle("arb_rst");
    for (int i = 0; i < 6; i++) begin
      q0.push_back(8'h00 + 8'(i));
      q1.push_back(8'h20 + 8'(i));
    end
    cls_log.delete();
    reset_L = 1;
    for (int i = 0; i < 18; i++) cycle("arb");
    check("arb.count", 32'(cls_log.size()), 32'd12);
    for (int i = 0; i < 12 && i < cls_log.size(); i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      check($sformatf("arb.order%0d", i), 32'(cls_log[i]), 32'(i % 2));
`else
      check($sformatf("arb.order%0d", i), 32'(cls_log[i]), (i < 6) ? 32'd0 : 32'd1);
`endif
    end

    // Reset asserted while ACTIVE, then INIT re-run.
    reset_L = 0;
    cycle("rst_act"); cycle("rst_act");
    for (int i = 0; i < 4; i++) q0.push_back(8'h40 + 8'(i));
    reset_L = 1;
    for (int i = 0; i < 5; i++) cycle("rst_act_run");
    check("rst_act.was_active", 32'(state), 32'd3);
    reset_L = 0;
    cycle("rst_act_mid");
    reset_L = 1;
    for (int i = 0; i < 6; i++) cycle("rst_act_rerun");

    // Counter wrap: 257 words to dest0.
    reset_L = 0;
    cycle("wrap_rst"); cycle("wrap_rst");
    q0.delete(); q1.delete();
    for (int i = 0; i < 257; i++) q0.push_back(8'($urandom) & 8'hEF);
    reset_L = 1;
    for (int i = 0; i < 265; i++) cycle("wrap");
    check("wrap.cnt_dest0", 32'(cnt_dest0), 32'd1);
    check("wrap.cnt_dest1", 32'(cnt_dest1), 32'd0);

    // Randomized traffic, backpressure and occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) != 0 && q0.size() < 6) q0.push_back(8'($urandom));
      if ($urandom_range(0, 2) != 0 && q1.size() < 6) q1.push_back(8'($urandom));
      d0_almost_full = ($urandom_range(0, 3) == 0);
      d1_almost_full = ($urandom_range(0, 3) == 0);
      reset_L = ($urandom_range(0, 79) != 0);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
